conv1d_frame_tx: RTL
====================

// Module: conv1d_frame_tx
// PURPOSE
//  Transmit side of the conv1d frame interface. Collects feature vectors one at a time from
//  the upstream feature extractor into ping-pong frame banks, then streams each complete
//  frame of FRAME_SIZE vectors into conv1d with valid/last/ready handshaking.
//  Decouples bursty upstream production from conv1d's recycle phase, during which conv1d
//  drops ready. One bank fills while the other drains.
// PARAMETERS
//  FRAME_SIZE   50  vectors per frame (>= 2)
//  VECTOR_SIZE  1   BW-bit lanes per vector
//  BW           8   bits per lane, signed, two's complement
// PORTS
//  clk_i    in   1                 clock; all state updates on rising edge
//  rst_i_n  in   1                 reset, asynchronous, active-low
//  data_i   in   VECTOR_SIZE*BW    upstream vector
//  valid_i  in   1                 upstream vector valid
//  ready_o  out  1                 write bank has space; accept = valid_i & ready_o
//  data_o   out  VECTOR_SIZE*BW    vector to conv1d
//  valid_o  out  1                 data_o valid
//  last_o   out  1                 data_o is vector FRAME_SIZE-1 of the frame
//  ready_i  in   1                 conv1d ready; transfer = valid_o & ready_i
// BEHAVIOUR
//  Reset: both banks empty, wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0.
//   Outputs at reset: ready_o=1, valid_o=0, last_o=0, data_o=0. Bank contents are not reset.
//  State per bank: full flag (1 bit). wr_idx, rd_idx counters: $clog2(FRAME_SIZE) bits.
//  Write side:
//   - ready_o = !full[wr_bank], combinational from registers only.
//   - On accept: bank[wr_bank][wr_idx] <= data_i.
//   - wr_idx==FRAME_SIZE-1 on accept: full[wr_bank]<=1, wr_idx<=0, wr_bank toggles.
//   - Otherwise wr_idx increments.
//  Read side, two-state FSM:
//   - IDLE: valid_o=0. Moves to SEND when full[rd_bank]==1.
//     The first vector is visible the cycle after the completing write (1-cycle latency).
//   - SEND: valid_o=1, data_o = bank[rd_bank][rd_idx], last_o = (rd_idx==FRAME_SIZE-1).
//   - SEND, transfer with last_o=0: rd_idx increments.
//   - SEND, transfer with last_o=1: full[rd_bank]<=0, rd_idx<=0, rd_bank toggles.
//     Next state is SEND if the other bank is already full (back-to-back frames, no bubble);
//     otherwise IDLE.
//   - SEND, ready_i=0: data_o, valid_o and last_o are held stable. valid_o never drops
//     mid-frame.
//  Simultaneous events:
//   - The write completing bank A and the read releasing bank B in the same cycle are both
//     honoured. Full-flag set and clear hit different banks, so there is no conflict.
//   - The read releasing bank X while the writer is stalled on X: ready_o rises the next
//     cycle.
//  Boundaries:
//   - Both banks full: ready_o=0. Upstream must hold its data; nothing is dropped or
//     overwritten.
//   - A bank is never read before it is full and never written while full.
//   - No partial frames are ever emitted.
//  Reset mid-operation: asynchronous return to the reset state. Partial and pending frames
//   are discarded. valid_o falls immediately.
//  Frame order is strictly FIFO: bank fill order equals emission order. Data is passed
//   bit-exact, with no arithmetic.
// STRUCTURE
//  Shared package conv_pkg holds:
//   - BW = 8
//   - default FRAME_SIZE and VECTOR_SIZE
//   - typedef vec_t = logic signed [VECTOR_SIZE*BW-1:0]
//   - read FSM state enum {TX_IDLE, TX_SEND}
//  Sub-module frame_bank (one write port, one combinational read mux, FRAME_SIZE entries),
//   instantiated twice. Top-level logic holds the counters, full flags, bank selects and
//   the FSM.
// TESTING
//  1. FRAME_SIZE=4. Write 1,2,3,4 on consecutive cycles with ready_i=1.
//     -> valid_o rises the cycle after 4 is accepted; data_o shows 1,2,3,4;
//        last_o is high only with 4.
//  2. Write 8 vectors 1..8 back-to-back with ready_i=1.
//     -> two frames emitted with no idle cycle between 4 and 5; ready_o stays 1 throughout.
//  3. Hold ready_i=0 and write 12 vectors.
//     -> ready_o=0 after the 8th accept; vectors 9-12 stall. Then raise ready_i:
//        output is 1..8, then 9..12; no vector is lost or duplicated.
//  4. Toggle ready_i randomly mid-frame.
//     -> data_o, valid_o and last_o are stable whenever ready_i=0; sequence is intact.
//  5. Assert rst_i_n=0 after 2 writes and while frame 1 is being sent.
//     -> valid_o=0 and ready_o=1 immediately. The next 4 writes produce a clean frame
//        containing only the new data.
//  6. Signed extremes: VECTOR_SIZE=2, lanes {-128,127}.
//     -> output is bit-identical, with lane order preserved.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the conv1d frame interface: lane width, default
// frame geometry, the default vector type and the transmit FSM states.
package conv_pkg;

  localparam int BW              = 8;
  localparam int FRAME_SIZE_DEF  = 50;
  localparam int VECTOR_SIZE_DEF = 1;

  typedef logic signed [VECTOR_SIZE_DEF*BW-1:0] vec_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/conv1d_frame_tx_frame_bank.sv
// One frame bank: FRAME_SIZE entries, a single synchronous write port and a
// combinational read mux. Contents are deliberately left unreset.
module frame_bank
  import conv_pkg::*;
#(
  parameter int DEPTH = FRAME_SIZE_DEF,
  parameter int WIDTH = VECTOR_SIZE_DEF * BW
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic signed [WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic signed [WIDTH-1:0]    rd_data
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // Store the incoming vector at the current write slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conv1d_frame_tx.sv
// Transmit side of the conv1d frame interface. Two ping-pong banks: the
// writer fills one while the read FSM streams the other as a complete frame
// with valid/last/ready handshaking. Frames leave in the order they filled.
module conv1d_frame_tx
  import conv_pkg::*;
#(
  parameter int FRAME_SIZE  = FRAME_SIZE_DEF,
  parameter int VECTOR_SIZE = VECTOR_SIZE_DEF
) (
  input  logic                               clk_i,
  input  logic                               rst_i_n,
  input  logic signed [VECTOR_SIZE*BW-1:0]   data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic signed [VECTOR_SIZE*BW-1:0]   data_o,
  output logic                               valid_o,
  output logic                               last_o,
  input  logic                               ready_i
);

  localparam int W  = VECTOR_SIZE * BW;
  localparam int AW = $clog2(FRAME_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_SIZE - 1);

  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            wr_bank;
  logic            rd_bank;
  logic            other_bank;
  logic [1:0]      full;
  logic [1:0]      bank_we;
  logic [1:0]      fill_done;
  logic [1:0]      release_mask;
  logic            accept;
  logic            xfer;
  logic            wr_last;
  logic            rd_last;
  logic signed [W-1:0] rd_data [2];
  tx_state_e       state;
  tx_state_e       state_next;

  assign ready_o    = ~full[wr_bank];
  assign accept     = valid_i & ready_o;
  assign xfer       = valid_o & ready_i;
  assign wr_last    = (wr_idx == LAST_IDX);
  assign rd_last    = (rd_idx == LAST_IDX);
  assign other_bank = ~rd_bank;

  assign bank_we[0] = accept & ~wr_bank;
  assign bank_we[1] = accept &  wr_bank;

  // A bank becomes full on the accept that writes its final slot.
  assign fill_done  = bank_we & {2{wr_last}};

  // The bank being read is released on the transfer of its last vector.
  assign release_mask[0] = xfer & rd_last & ~rd_bank;
  assign release_mask[1] = xfer & rd_last &  rd_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .DEPTH (FRAME_SIZE),
      .WIDTH (W)
    ) u_bank (
      .clk     (clk_i),
      .wr_en   (bank_we[b]),
      .wr_addr (wr_idx),
      .wr_data (data_i),
      .rd_addr (rd_idx),
      .rd_data (rd_data[b])
    );
  end

  // Write pointer: advance per accept, hop to the other bank after the last slot.
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      wr_idx  <= '0;
      wr_bank <= 1'b0;
    end else if (accept) begin
      if (wr_last) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx  <= wr_idx + AW'(1);
      end
    end
  end

  // Full flags: set and clear always target different banks, so OR then mask.
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      full <= '0;
    end else begin
      full <= (full | fill_done) & ~release_mask;
    end
  end

  // Read pointer: advance per transfer, hop to the other bank after the last vector.
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      rd_idx  <= '0;
      rd_bank <= 1'b0;
    end else if (xfer) begin
      if (rd_last) begin
        rd_idx  <= '0;
        rd_bank <= ~rd_bank;
      end else begin
        rd_idx  <= rd_idx + AW'(1);
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state <= TX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read FSM next state. A fill completing this very cycle counts as full, which
  // gives one-cycle latency from the completing write and keeps back-to-back
  // frames bubble-free when the next frame finishes alongside the current one.
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE: begin
        if (full[rd_bank] | fill_done[rd_bank]) begin
          state_next = TX_SEND;
        end
      end
      TX_SEND: begin
        if (xfer && rd_last) begin
          state_next = (full[other_bank] | fill_done[other_bank]) ? TX_SEND : TX_IDLE;
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // Read FSM outputs. While stalled nothing feeding these changes, so they hold.
  always_comb begin
    valid_o = 1'b0;
    last_o  = 1'b0;
    data_o  = '0;
    if (state == TX_SEND) begin
      valid_o = 1'b1;
      last_o  = rd_last;
      data_o  = rd_data[rd_bank];
    end
  end

endmodule
